// File: rtl/seq_div_u32_pkg.sv
// Shared constants and state encoding for the sequential unsigned divider.
package seq_div_u32_pkg;

   localparam int DATA_INDEX_LIMIT = 31;
   localparam int DATA_W           = DATA_INDEX_LIMIT + 1;
   localparam int DIV_CNT_W        = 6;
   localparam int DIV_CNT_LIMIT    = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_div_u32_addsub.sv
// Ripple-carry adder/subtractor: y = a + b when sna=0, y = a - b when sna=1.
// co is the carry out of the top bit; in subtract mode co=1 means no borrow.
module seq_div_u32_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sna,
   output logic [WIDTH-1:0] y,
   output logic             co
);

   logic [WIDTH-1:0] bx;

   assign bx = b ^ {WIDTH{sna}};

   always_comb begin
      logic carry;
      carry = sna;
      y     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y[i]  = a[i] ^ bx[i] ^ carry;
         carry = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/seq_div_u32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// started over a START/BUSY/DONE handshake.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | iterating, one quotient bit per edge (BUSY=1)
// FIN   | results valid, DONE=1 for one cycle; accepts a new START
module seq_div_u32
   import seq_div_u32_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic [WIDTH-1:0] QUOTIENT,
   output logic [WIDTH-1:0] REMAINDER,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV_BY_ZERO
);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] r, r_nxt, q, q_nxt, d, d_nxt;
   logic [WIDTH-1:0] quot_nxt, rem_nxt;
   logic             dbz_nxt;
   logic [WIDTH-1:0] rs, y;
   logic             rmsb, co;

   // Shifted partial remainder; rmsb is the 33rd bit that falls off the top.
   assign rmsb = r[WIDTH-1];
   assign rs   = {r[WIDTH-2:0], q[WIDTH-1]};

   seq_div_u32_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (rs),
      .b   (d),
      .sna (1'b1),
      .y   (y),
      .co  (co)
   );

   assign BUSY = (state == RUN);
   assign DONE = (state == FIN);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      r_nxt     = r;
      q_nxt     = q;
      d_nxt     = d;
      quot_nxt  = QUOTIENT;
      rem_nxt   = REMAINDER;
      dbz_nxt   = DIV_BY_ZERO;
      case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            if (START) begin
               if (DIVISOR != '0) begin
                  r_nxt     = '0;
                  q_nxt     = DIVIDEND;
                  d_nxt     = DIVISOR;
                  cnt_nxt   = '0;
                  dbz_nxt   = 1'b0;
                  state_nxt = RUN;
               end else begin
                  quot_nxt  = '1;
                  rem_nxt   = DIVIDEND;
                  dbz_nxt   = 1'b1;
                  state_nxt = FIN;
               end
            end
         end
         RUN: begin
            if (rmsb | co) begin
               r_nxt = y;
               q_nxt = {q[WIDTH-2:0], 1'b1};
            end else begin
               r_nxt = rs;
               q_nxt = {q[WIDTH-2:0], 1'b0};
            end
            cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt == CNT_W'(DIV_CNT_LIMIT)) begin
               quot_nxt  = q_nxt;
               rem_nxt   = r_nxt;
               state_nxt = FIN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         QUOTIENT    <= '0;
         REMAINDER   <= '0;
         DIV_BY_ZERO <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         r           <= r_nxt;
         q           <= q_nxt;
         d           <= d_nxt;
         QUOTIENT    <= quot_nxt;
         REMAINDER   <= rem_nxt;
         DIV_BY_ZERO <= dbz_nxt;
      end
   end

endmodule

// File: tb/tb_seq_div_u32.sv
// Self-checking bench for seq_div_u32: behavioural model compared every cycle,
// plus directed literal cases and randomized traffic.
module tb_seq_div_u32;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [31:0] DIVIDEND, DIVISOR;
   logic [31:0] QUOTIENT, REMAINDER;
   logic        BUSY, DONE, DIV_BY_ZERO;

   int total = 0;
   int bad   = 0;

   seq_div_u32 dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .DIVIDEND    (DIVIDEND),
      .DIVISOR     (DIVISOR),
      .QUOTIENT    (QUOTIENT),
      .REMAINDER   (REMAINDER),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .DIV_BY_ZERO (DIV_BY_ZERO)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each accepted op yields its result a fixed number of
   // edges later; results are plain / and %.
   int          cyc       = 0;
   int          m_done_at = 0;
   bit          m_active  = 1'b0;
   bit          m_nz      = 1'b0;
   logic [31:0] m_pend_q  = '0, m_pend_r = '0;
   logic [31:0] exp_q     = '0, exp_r = '0;
   logic        exp_dbz   = 1'b0;
   bit          armed     = 1'b0;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_active = 1'b0;
         exp_q    = '0;
         exp_r    = '0;
         exp_dbz  = 1'b0;
      end else begin
         bit busy_before;
         cyc = cyc + 1;
         busy_before = m_active && ((cyc - 1) < m_done_at);
         if (m_active && m_nz && cyc == m_done_at) begin
            exp_q = m_pend_q;
            exp_r = m_pend_r;
         end
         if (START && !busy_before) begin
            m_active = 1'b1;
            if (DIVISOR != 0) begin
               m_nz      = 1'b1;
               m_done_at = cyc + 32;
               m_pend_q  = DIVIDEND / DIVISOR;
               m_pend_r  = DIVIDEND % DIVISOR;
               exp_dbz   = 1'b0;
            end else begin
               m_nz      = 1'b0;
               m_done_at = cyc;
               exp_q     = 32'hFFFF_FFFF;
               exp_r     = DIVIDEND;
               exp_dbz   = 1'b1;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (armed && !RST) begin
         chk("model_done", {31'd0, DONE}, {31'd0, m_active && cyc == m_done_at});
         chk("model_busy", {31'd0, BUSY}, {31'd0, m_active && cyc < m_done_at});
         chk("model_quotient", QUOTIENT, exp_q);
         chk("model_remainder", REMAINDER, exp_r);
         chk("model_dbz", {31'd0, DIV_BY_ZERO}, {31'd0, exp_dbz});
      end
   end

   // Waits for DONE after START has been driven; optionally injects a second
   // START pulse at observation number inj while the first op is running.
   task automatic op_wait(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                          output int lat, output int nbusy);
      lat   = 0;
      nbusy = 0;
      do begin
         @(negedge CLK);
         lat++;
         if (BUSY) nbusy++;
         if (lat == 1) begin
            START    = 1'b0;
            DIVIDEND = $urandom;
            DIVISOR  = $urandom;
         end
         if (inj > 1 && lat == inj) begin
            START    = 1'b1;
            DIVIDEND = ia;
            DIVISOR  = ib;
         end
         if (inj > 1 && lat == inj + 1) begin
            START    = 1'b0;
            DIVIDEND = $urandom;
            DIVISOR  = $urandom;
         end
      end while (!DONE && lat < 60);
      if (!DONE) chk("done_timeout", 32'd0, 32'd1);
      START = 1'b0;
   endtask

   task automatic run_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int elat, input int ebusy);
      int lat, nb;
      START    = 1'b1;
      DIVIDEND = a;
      DIVISOR  = b;
      op_wait(0, '0, '0, lat, nb);
      chk({tag, "_q"}, QUOTIENT, eq);
      chk({tag, "_r"}, REMAINDER, er);
      chk({tag, "_dbz"}, {31'd0, DIV_BY_ZERO}, {31'd0, edbz});
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_busy"}, nb, ebusy);
   endtask

   initial begin
      int lat, nb, ndone;
      RST      = 1'b1;
      START    = 1'b0;
      DIVIDEND = '0;
      DIVISOR  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_q", QUOTIENT, 32'd0);
      chk("rst_r", REMAINDER, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_done", {31'd0, DONE}, 32'd0);
      chk("rst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
      RST   = 1'b0;
      armed = 1'b1;
      @(negedge CLK);

      run_chk("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32);
      @(negedge CLK);
      run_chk("dmsb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, 32);
      run_chk("dbig", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 33, 32);
      @(negedge CLK);
      run_chk("dzero", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0);
      run_chk("dnum0", 32'd0, 32'd17, 32'd0, 32'd0, 1'b0, 33, 32);

      // Ignored START mid-run, then a back-to-back START in the DONE cycle.
      @(negedge CLK);
      START    = 1'b1;
      DIVIDEND = 32'd1000;
      DIVISOR  = 32'd3;
      op_wait(5, 32'd5, 32'd5, lat, nb);
      chk("seq1_q", QUOTIENT, 32'd333);
      chk("seq1_r", REMAINDER, 32'd1);
      chk("seq1_lat", lat, 33);
      run_chk("seq2", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33, 32);

      // Asynchronous reset mid-operation.
      @(negedge CLK);
      START    = 1'b1;
      DIVIDEND = 32'd50000;
      DIVISOR  = 32'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         START = 1'b0;
      end
      #2 RST = 1'b1;
      #1;
      chk("arst_q", QUOTIENT, 32'd0);
      chk("arst_r", REMAINDER, 32'd0);
      chk("arst_busy", {31'd0, BUSY}, 32'd0);
      chk("arst_done", {31'd0, DONE}, 32'd0);
      chk("arst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
      @(negedge CLK);
      RST   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (DONE) ndone++;
      end
      chk("arst_no_done", ndone, 0);
      run_chk("arst_again", 32'd50000, 32'd7, 32'd7142, 32'd6, 1'b0, 33, 32);

      for (int k = 0; k < 150; k++) begin
         logic [31:0] a, b;
         int sel, inj;
         sel = $urandom_range(0, 9);
         a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (sel == 0)      b = 32'd0;
         else if (sel <= 3) b = 32'($urandom_range(1, 15));
         else if (sel <= 5) b = 32'h8000_0000 | $urandom;
         else               b = $urandom;
         inj      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : 0;
         START    = 1'b1;
         DIVIDEND = a;
         DIVISOR  = b;
         op_wait(inj, $urandom, $urandom_range(0, 1) == 0 ? 32'd0 : $urandom, lat, nb);
         if ($urandom_range(0, 1) == 0) @(negedge CLK);
      end

      repeat (3) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule

// File: doc/seq_div_u32.md
Name: seq_div_u32

Overview:
- Multi-cycle unsigned 32-bit restoring divider for the machine's ALU/multi-cycle execute path.
- Each iteration feeds a partial remainder and the divisor into the existing 32-bit ripple-carry add/subtract unit in subtract mode, and consumes its sum and carry-out to choose between restore and commit.
- Sits beside the ALU and is started by the control unit for DIV/REM instructions.
- Reports results over a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width; tied to the project data width (DATA_INDEX_LIMIT+1); only 32 is supported.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request a division; sampled only when BUSY=0.
- DIVIDEND  input  32  numerator; captured on an accepted START.
- DIVISOR  input  32  denominator; captured on an accepted START.
- QUOTIENT  output  32  result quotient; registered; holds until the next accepted START.
- REMAINDER  output  32  result remainder; registered; holds until the next accepted START.
- BUSY  output  1  high while an operation is in progress; START is ignored while high.
- DONE  output  1  single-cycle pulse; QUOTIENT/REMAINDER valid in the same cycle.
- DIV_BY_ZERO  output  1  registered flag; set with DONE when DIVISOR=0; cleared on the next accepted START.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State=IDLE; counter=0; internal R/Q/D registers=0.
  - QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV_BY_ZERO=0.
  - An in-flight operation is discarded; no DONE is produced for it.
- States: IDLE, RUN, FIN.
  - IDLE: if START=1 and DIVISOR!=0, load R=0, Q=DIVIDEND, D=DIVISOR, counter=0, clear DIV_BY_ZERO, go to RUN.
  - IDLE: if START=1 and DIVISOR=0, go to FIN with QUOTIENT=32'hFFFFFFFF, REMAINDER=DIVIDEND, DIV_BY_ZERO=1.
  - RUN: one iteration per edge. On the edge where counter==WIDTH-1, write QUOTIENT/REMAINDER and go to FIN.
  - FIN: DONE=1 for exactly one cycle, BUSY=0. A START in this cycle is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
- Iteration (RUN):
  - {Rmsb, Rs} = {R, Q[31]}, where Rs is the 32-bit shifted remainder and Rmsb=R[31] is the bit shifted out.
  - The adder/subtractor computes Y=Rs-D with SnA=1; CO=1 means no borrow.
  - If Rmsb | CO: R<=Y and Q<={Q[30:0],1}. Otherwise: R<=Rs and Q<={Q[30:0],0}.
  - The Rmsb term handles divisors >= 2^31, where the true partial remainder needs 33 bits. The 32-bit Y is correct modulo 2^32.
  - counter increments every RUN cycle.
- Latency:
  - Nonzero divisor: START sampled at edge E0; iterations on edges E1..E32; FIN (DONE=1) in the cycle after E32, i.e. 33 cycles from START to DONE.
  - Zero divisor: DONE in the cycle after E0, i.e. 1 cycle.
- BUSY=1 exactly in RUN.
- START while BUSY=1 is ignored: no queuing, and operands are not re-captured.
- DIVIDEND/DIVISOR may change freely after the accepting edge.
- DIVIDEND < DIVISOR gives QUOTIENT=0, REMAINDER=DIVIDEND; no special path.
- DIVIDEND=0 gives QUOTIENT=0, REMAINDER=0.
- The adder/subtractor is purely combinational; no other arithmetic operators are used in the datapath. The counter may use the behavioural +1.

Decomposition:
- prj_definition.v provides DATA_INDEX_LIMIT and the data width.
- A new DIV_CNT_LIMIT macro (31) goes in the same file.
- State encodings (2 bits: IDLE=0, RUN=1, FIN=2) are local parameters of this block.
- One sub-module instance: RC_ADD_SUB_32 (existing), with SnA tied high.
- Everything else (counter, R/Q/D registers, FSM) lives in this file.

Test Plan:
- 100 / 7 → after 33 cycles: DONE pulse, QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0; BUSY high for 32 cycles.
- 32'hFFFFFFFF / 32'h80000000 → QUOTIENT=1, REMAINDER=32'h7FFFFFFF (exercises the Rmsb path).
- 32'hFFFFFFFE / 32'hFFFFFFFF → QUOTIENT=0, REMAINDER=32'hFFFFFFFE.
- 1234 / 0 → DONE one cycle after START, QUOTIENT=32'hFFFFFFFF, REMAINDER=1234, DIV_BY_ZERO=1.
- Sequence on a single run:
  - Start 1000/3.
  - Pulse START with 5/5 at RUN cycle 5 → ignored; result is QUOTIENT=333, REMAINDER=1.
  - Issue START 9/4 during the DONE cycle → the second DONE arrives 33 cycles later with QUOTIENT=2, REMAINDER=1.
- Assert RST at RUN cycle 10 of 50000/7 → all outputs 0 immediately (asynchronous), no DONE. A fresh START of 50000/7 afterwards gives QUOTIENT=7142, REMAINDER=6.
